rs422_uart_tx_fifo: RTL
=======================

# rs422_uart_tx_fifo

Buffered RS-422 transmit channel: accepts bytes from on-chip logic over a valid/ready handshake, queues them in a small synchronous FIFO and serializes them as asynchronous UART frames on the RS-422 TXD pin (Y/Z driver input). It is the initiator-side counterpart to the per-channel echo receivers in the RS-422 top level. Host logic can push bursts without tracking baud timing. One instance per RS-422 channel.

## Interface
- CLK_FRE, 50, system clock frequency in MHz
- BAUD_RATE, 115200, line rate in bit/s
- FIFO_DEPTH, 16, byte queue depth; power of two, ≥2
- sys_clk  in  1  system clock. One clock; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset
- tx_data  in  8  byte to queue
- tx_data_valid  in  1  tx_data is valid this cycle
- tx_data_ready  out  1  FIFO can accept; a byte is written on a rising edge where valid && ready
- tx_busy  out  1  high while a frame is on the line or the FIFO is non-empty
- fifo_level  out  $clog2(FIFO_DEPTH)+1  bytes currently queued (excludes the byte in the shifter)
- rs422_tx  out  1  serial line, idle high

## Operation
- Bit period CYCLE = CLK_FRE*1000000/BAUD_RATE, integer division with truncation. 50 MHz / 115200 gives 434.
- The baud counter counts 0..CYCLE-1 and restarts at each bit boundary. It is held at 0 in IDLE.
- Frame: start bit (0), 8 data bits LSB first, [parity], 1 stop bit (1).
- FSM states: IDLE, START, DATA, PARITY (only when the macro is defined), STOP.
- IDLE: if the FIFO is non-empty, pop the head into the shift register, then go to START.
- START → DATA after CYCLE clocks. DATA holds each bit CYCLE clocks. A bit index 0..7 tracks the current bit. After bit 7 the FSM goes to PARITY or STOP.
- STOP lasts CYCLE clocks. At its end, if the FIFO is non-empty, pop and go straight to START with no idle gap. Otherwise go to IDLE.
- FIFO: tx_data_ready = (fifo_level != FIFO_DEPTH). It depends only on the registered level, not on a same-cycle pop.
- A push while full is ignored and the data is dropped. Simultaneous push and pop leave the level unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Reset values: rs422_tx=1, tx_data_ready=1, tx_busy=0, fifo_level=0. FSM goes to IDLE, counters go to 0.
- Reset mid-frame aborts the frame: the line is high after the reset edge and the FIFO is flushed. No partial frame resumes.

## Timing
- All outputs are registered.
- Write accepted at edge k → fifo_level increments at k. The FSM pops at edge k+1. rs422_tx falls at edge k+2.
- Each bit is exactly CYCLE clocks. A 10-bit frame occupies 10*CYCLE clocks, or 11*CYCLE with parity.
- tx_busy rises at edge k and falls on the edge where STOP completes with an empty FIFO.
- tx_data_ready returns high one clock after the pop that leaves the FIFO non-full.

## Configuration
- RS422_TX_PARITY_EN defined: even parity bit (XOR of the 8 data bits) is inserted between DATA and STOP. Frame is 11 bits.
- Not defined: the PARITY state and its logic are absent. Frame is 8N1, 10 bits.

## Structure
- Shared package rs422_pkg holds:
  - the tx state enum (IDLE, START, DATA, PARITY, STOP);
  - a constant function computing CYCLE from CLK_FRE/BAUD_RATE, for reuse by the receive side.
- Sub-module rs422_tx_fifo: synchronous FIFO with push/pop, full/empty and level, parameterized by depth and width. The top holds the baud counter, FSM and shifter.

## Test plan
- Push 0x55 once (defaults) → rs422_tx low at k+2 for 434 clocks, then bits 1,0,1,0,1,0,1,0 at 434 clocks each, stop high, tx_busy low after 4340 clocks.
- Push 0xA5 then 0x3C on consecutive cycles → two frames with no idle gap, 8680 clocks total, LSB-first patterns checked.
- Hold valid for 20 cycles while the line is busy → fifo_level reaches 16, ready low, 4 bytes dropped, exactly 17 frames sent (1 in shifter + 16 queued).
- Assert rst during data bit 3 → rs422_tx=1 and fifo_level=0 after that edge; next pushed byte 0x81 sends a clean full frame.
- With RS422_TX_PARITY_EN, push 0x07 → parity bit 1, frame 4774 clocks; push 0x03 → parity bit 0.
- Push and pop in the same cycle at level 5 → level stays 5, data order preserved.

Source files
------------

// File: rtl/rs422_pkg.sv
// rs422_pkg: types and helpers shared by the RS-422 transmit and receive channels.
package rs422_pkg;

  // Transmit FSM states; ST_PARITY is only reachable when RS422_TX_PARITY_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Clocks per bit: clk_fre [MHz] * 1e6 / baud_rate, truncated.
  function automatic int unsigned calc_cycle(input int unsigned clk_fre,
                                             input int unsigned baud_rate);
    return (clk_fre * 32'd1000000) / baud_rate;
  endfunction

endpackage

// File: rtl/rs422_tx_fifo.sv
// rs422_tx_fifo: synchronous FIFO with registered level and ready; pushes while full are dropped.
module rs422_tx_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic                     empty_c,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     ready
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [LW-1:0]    level_next;
  logic             do_push;
  logic             do_pop;

  assign empty_c = (level == '0);
  assign head_c  = mem[rptr];
  assign do_push = push && (level != LW'(DEPTH));
  assign do_pop  = pop && !empty_c;

  // Occupancy after this cycle's accepted push/pop.
  always_comb begin
    level_next = level;
    if (do_push && !do_pop) begin
      level_next = level + LW'(1);
    end else if (!do_push && do_pop) begin
      level_next = level - LW'(1);
    end
  end

  // Pointers, level and ready flag; pointers wrap naturally at the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
      ready <= 1'b1;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      level <= level_next;
      ready <= (level_next != LW'(DEPTH));
    end
  end

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= push_data;
  end

endmodule

// File: rtl/rs422_uart_tx_fifo.sv
// rs422_uart_tx_fifo: FIFO-buffered UART transmitter driving the RS-422 TXD pin.
// Frame is 8N1 by default; defining RS422_TX_PARITY_EN inserts an even-parity bit (8E1).
module rs422_uart_tx_fifo
  import rs422_pkg::*;
#(
  parameter int unsigned CLK_FRE    = 50,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                          sys_clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_data_valid,
  output logic                          tx_data_ready,
  output logic                          tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          rs422_tx
);

  localparam int unsigned CYCLE = calc_cycle(CLK_FRE, BAUD_RATE);
  localparam int unsigned CW    = (CYCLE > 1) ? $clog2(CYCLE) : 1;

  tx_state_e     state;
  tx_state_e     state_next;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    frame_data;
  logic [7:0]    fifo_head_c;
  logic          fifo_empty_c;
  logic          push_c;
  logic          pop_c;
  logic          bit_done_c;
  logic          tx_next_c;
  logic          busy_next_c;

  assign push_c     = tx_data_valid && tx_data_ready;
  assign bit_done_c = (baud_cnt == CW'(CYCLE - 1));

  rs422_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (rst),
    .push      (push_c),
    .push_data (tx_data),
    .pop       (pop_c),
    .head_c    (fifo_head_c),
    .empty_c   (fifo_empty_c),
    .level     (fifo_level),
    .ready     (tx_data_ready)
  );

  // FSM state register.
  always_ff @(posedge sys_clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Next-state logic; STOP chains straight into START when more bytes are queued.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (!fifo_empty_c) state_next = ST_START;
      ST_START: if (bit_done_c) state_next = ST_DATA;
`ifdef RS422_TX_PARITY_EN
      ST_DATA:   if (bit_done_c && (bit_idx == 3'd7)) state_next = ST_PARITY;
      ST_PARITY: if (bit_done_c) state_next = ST_STOP;
`else
      ST_DATA:   if (bit_done_c && (bit_idx == 3'd7)) state_next = ST_STOP;
`endif
      ST_STOP:  if (bit_done_c) state_next = fifo_empty_c ? ST_IDLE : ST_START;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Output decode: FIFO pop strobe and next line/busy values.
  always_comb begin
    pop_c     = 1'b0;
    tx_next_c = 1'b1;
    case (state)
      ST_IDLE:   pop_c = !fifo_empty_c;
      ST_START:  tx_next_c = 1'b0;
      ST_DATA:   tx_next_c = frame_data[bit_idx];
`ifdef RS422_TX_PARITY_EN
      ST_PARITY: tx_next_c = ^frame_data;
`endif
      ST_STOP:   pop_c = bit_done_c && !fifo_empty_c;
      default:   tx_next_c = 1'b1;
    endcase
    busy_next_c = (state_next != ST_IDLE) || push_c || !fifo_empty_c;
  end

  // Baud counter, bit index, byte latch and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      baud_cnt   <= '0;
      bit_idx    <= '0;
      frame_data <= '0;
      rs422_tx   <= 1'b1;
      tx_busy    <= 1'b0;
    end else begin
      rs422_tx <= tx_next_c;
      tx_busy  <= busy_next_c;
      if ((state == ST_IDLE) || bit_done_c) baud_cnt <= '0;
      else                                  baud_cnt <= baud_cnt + CW'(1);
      if (state != ST_DATA)  bit_idx <= '0;
      else if (bit_done_c)   bit_idx <= bit_idx + 3'd1;
      if (pop_c) frame_data <= fifo_head_c;
    end
  end

endmodule
